// File: rtl/operand_recover_pkg.sv
// Shared encodings and widths for the operand recovery path.
package operand_recover_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_DIFF = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_RANGE   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  // A 10-bit signed value fits an 8-bit signed operand when its top three
  // bits are all equal (pure sign extension).
  function automatic logic fits_op(input logic [RES_W:0] v);
    return (v[RES_W:OP_W-1] == '0) || (v[RES_W:OP_W-1] == '1);
  endfunction

endpackage

// File: rtl/operand_recover_solver.sv
// Combinational solve of (a+b, a-b) back into (a, b) with legality flags.
module operand_solver
  import operand_recover_pkg::*;
(
  input  logic [RES_W-1:0] s,
  input  logic [RES_W-1:0] d,
  output logic [OP_W-1:0]  a,
  output logic [OP_W-1:0]  b,
  output logic             parity_ok,
  output logic             range_ok
);

  logic signed [RES_W:0] sum_w;
  logic signed [RES_W:0] diff_w;
  logic signed [RES_W:0] a_w;
  logic signed [RES_W:0] b_w;

  // Widen by one bit so s+d and s-d never overflow, then halve.
  always_comb begin
    sum_w     = $signed({s[RES_W-1], s}) + $signed({d[RES_W-1], d});
    diff_w    = $signed({s[RES_W-1], s}) - $signed({d[RES_W-1], d});
    a_w       = sum_w >>> 1;
    b_w       = diff_w >>> 1;
    a         = a_w[OP_W-1:0];
    b         = b_w[OP_W-1:0];
    // a+b and a-b always share their LSB; a mismatch means a corrupted word.
    parity_ok = (s[0] == d[0]);
    range_ok  = fits_op(a_w) && fits_op(b_w);
  end

endmodule

// File: rtl/operand_recover.sv
// Rebuilds (a, b) operand pairs from a tagged stream of direct and
// sum/difference result words, with duplicate, parity, range and
// stale-pair timeout reporting.
module operand_recover
  import operand_recover_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       select,
  input  logic [RES_W-1:0] c,
  output logic             out_valid,
  output logic [OP_W-1:0]  a_out,
  output logic [OP_W-1:0]  b_out,
  output logic             src,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             dup
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // Slot storage
  logic [OP_W-1:0]  a_val;
  logic [OP_W-1:0]  b_val;
  logic [RES_W-1:0] s_val;
  logic [RES_W-1:0] d_val;
  logic             a_full;
  logic             b_full;
  logic             s_full;
  logic             d_full;
  logic [CNT_W-1:0] cnt;

  // Decode of the incoming word
  sel_e             sel_w;
  logic             wr_a;
  logic             wr_b;
  logic             wr_s;
  logic             wr_d;
  logic             direct_done;
  logic             derived_done;
  logic             dup_hit;
  logic             any_full;
  logic             idle_tick;
  logic             expire;
  logic [OP_W-1:0]  pair_a;
  logic [OP_W-1:0]  pair_b;
  logic [RES_W-1:0] solve_s;
  logic [RES_W-1:0] solve_d;
  logic [OP_W-1:0]  solved_a;
  logic [OP_W-1:0]  solved_b;
  logic             parity_ok;
  logic             range_ok;

  assign sel_w = sel_e'(select);

  // Classify the incoming word and look ahead at the slot contents it completes.
  always_comb begin
    wr_a         = in_valid && (sel_w == SEL_A);
    wr_b         = in_valid && (sel_w == SEL_B);
    wr_s         = in_valid && (sel_w == SEL_SUM);
    wr_d         = in_valid && (sel_w == SEL_DIFF);

    direct_done  = (wr_a && b_full) || (wr_b && a_full);
    derived_done = (wr_s && d_full) || (wr_d && s_full);
    dup_hit      = (wr_a && a_full) || (wr_b && b_full) ||
                   (wr_s && s_full) || (wr_d && d_full);

    pair_a       = wr_a ? c[OP_W-1:0] : a_val;
    pair_b       = wr_b ? c[OP_W-1:0] : b_val;
    solve_s      = wr_s ? c : s_val;
    solve_d      = wr_d ? c : d_val;

    any_full     = a_full || b_full || s_full || d_full;
    idle_tick    = !in_valid && any_full;
    expire       = (TIMEOUT > 0) && idle_tick && (cnt == CNT_LAST);
  end

  operand_solver u_solver (
    .s         (solve_s),
    .d         (solve_d),
    .a         (solved_a),
    .b         (solved_b),
    .parity_ok (parity_ok),
    .range_ok  (range_ok)
  );

  // Slot update, pair completion, error reporting and the stale-pair timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_val     <= '0;
      b_val     <= '0;
      s_val     <= '0;
      d_val     <= '0;
      a_full    <= 1'b0;
      b_full    <= 1'b0;
      s_full    <= 1'b0;
      d_full    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      src       <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      dup       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      dup       <= dup_hit;

      if (wr_a) begin
        a_val  <= c[OP_W-1:0];
        a_full <= 1'b1;
      end
      if (wr_b) begin
        b_val  <= c[OP_W-1:0];
        b_full <= 1'b1;
      end
      if (wr_s) begin
        s_val  <= c;
        s_full <= 1'b1;
      end
      if (wr_d) begin
        d_val  <= c;
        d_full <= 1'b1;
      end

      if (direct_done) begin
        a_full    <= 1'b0;
        b_full    <= 1'b0;
        out_valid <= 1'b1;
        src       <= 1'b0;
        a_out     <= pair_a;
        b_out     <= pair_b;
      end

      // The derived slots are released whether or not the solve is legal.
      if (derived_done) begin
        s_full <= 1'b0;
        d_full <= 1'b0;
        if (!parity_ok) begin
          err_valid <= 1'b1;
          err_code  <= ERR_PARITY;
        end else if (!range_ok) begin
          err_valid <= 1'b1;
          err_code  <= ERR_RANGE;
        end else begin
          out_valid <= 1'b1;
          src       <= 1'b1;
          a_out     <= solved_a;
          b_out     <= solved_b;
        end
      end

      // Expiry needs an idle cycle, so it never collides with a completion.
      if (in_valid || !any_full) begin
        cnt <= '0;
      end else if (expire) begin
        a_full    <= 1'b0;
        b_full    <= 1'b0;
        s_full    <= 1'b0;
        d_full    <= 1'b0;
        cnt       <= '0;
        err_valid <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (TIMEOUT > 0) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
